// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter granting icache/dcache line requests onto one cacheline-adaptor port.
// Adaptor-side outputs come only from registered state; the response path is combinational.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction in flight; arbitrate between pending requests
// SERVE_I | icache read driven to the adaptor, waiting for mem_resp
// SERVE_D | dcache read or writeback driven to the adaptor, waiting for mem_resp
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q;
    logic              op_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic i_req, d_req;
    logic grant_i, grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (grant_i) begin
                last_grant_q <= 1'b0;
                op_write_q   <= 1'b0;
                addr_q       <= i_pmem_address;
            end else if (grant_d) begin
                last_grant_q <= 1'b1;
                // A simultaneous read+write from the dcache is handled as a writeback.
                op_write_q   <= d_pmem_write;
                addr_q       <= d_pmem_address;
                wdata_q      <= d_pmem_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the cache that did not win last time is granted.
                if (i_req && (!d_req || last_grant_q)) begin
                    state_d = SERVE_I;
                    grant_i = 1'b1;
                end else if (d_req) begin
                    state_d = SERVE_D;
                    grant_d = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        mem_address  = addr_q;
        mem_wdata    = wdata_q;
        i_pmem_rdata = mem_rdata;
        d_pmem_rdata = mem_rdata;
        case (state_q)
            SERVE_I: begin
                mem_read    = ~op_write_q;
                mem_write   = op_write_q;
                i_pmem_resp = mem_resp;
            end
            SERVE_D: begin
                mem_read    = ~op_write_q;
                mem_write   = op_write_q;
                d_pmem_resp = mem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed client stimulus, a behavioural
// adaptor, and a monitor that checks every adaptor transaction and every cache response.
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        bit            wr;
        logic [LW-1:0] wdata;
    } grant_t;

    typedef struct {
        bit            is_d;
        logic [LW-1:0] data;
        int            cycles;
    } resp_t;

    grant_t exp_grant[$];
    resp_t  exp_resp[$];

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 4;
    bit stray = 1'b0;
    logic [LW-1:0] mem_model [logic [AW-1:0]];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] def_line(input logic [AW-1:0] a);
        return {8{a}};
    endfunction

    // Behavioural adaptor: completes after `lat` cycles of an asserted request.
    initial begin
        int cnt = 0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (stray) begin
                mem_resp  = 1'b1;
                mem_rdata = '0;
            end else if (mem_read || mem_write) begin
                cnt++;
                if (cnt == lat) begin
                    mem_resp = 1'b1;
                    if (mem_write) begin
                        mem_model[mem_address] = mem_wdata;
                        mem_rdata = '0;
                    end else if (mem_model.exists(mem_address)) begin
                        mem_rdata = mem_model[mem_address];
                    end else begin
                        mem_rdata = def_line(mem_address);
                    end
                end else begin
                    mem_resp  = 1'b0;
                    mem_rdata = '0;
                end
            end else begin
                cnt       = 0;
                mem_resp  = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    // Monitor: checks each adaptor transaction against the expected grant order and
    // each cache response against the expected response queue.
    initial begin
        bit     prev_act = 1'b0;
        bit     act;
        int     act_cnt  = 0;
        grant_t cur;
        resp_t  r;
        cur = '{addr: '0, wr: 1'b0, wdata: '0};
        forever begin
            @(negedge clk);
            #1;
            act = mem_read | mem_write;
            if (act && !prev_act) begin
                act_cnt = 1;
                if (exp_grant.size() == 0) begin
                    chk("unexpected_grant", {255'd0, act}, '0);
                end else begin
                    cur = exp_grant.pop_front();
                end
            end else if (act) begin
                act_cnt++;
            end
            if (act) begin
                chk("mem_address", mem_address, cur.addr);
                chk("mem_write", mem_write, cur.wr);
                chk("mem_read", mem_read, !cur.wr);
                if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
            end
            if (i_pmem_resp || d_pmem_resp) begin
                chk("resp_exclusive", {254'd0, i_pmem_resp, d_pmem_resp} == 256'd3, '0);
                if (exp_resp.size() == 0) begin
                    chk("unexpected_resp", {254'd0, i_pmem_resp, d_pmem_resp}, '0);
                end else begin
                    r = exp_resp.pop_front();
                    chk("resp_port_d", d_pmem_resp, r.is_d);
                    chk("resp_port_i", i_pmem_resp, !r.is_d);
                    chk("resp_rdata", r.is_d ? d_pmem_rdata : i_pmem_rdata, r.data);
                    chk("resp_latency", act_cnt, r.cycles);
                end
            end
            prev_act = act;
        end
    end

    task automatic run_i(input logic [AW-1:0] addr);
        int t = 0;
        i_pmem_address = addr;
        i_pmem_read    = 1'b1;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!i_pmem_resp && t < 200);
        if (!i_pmem_resp) begin
            n_cmp++;
            n_err++;
            $display("FAIL i_timeout: got no resp expected resp for addr %h", addr);
        end
        i_pmem_read = 1'b0;
    endtask

    task automatic run_d(input logic [AW-1:0] addr, input logic [LW-1:0] wd,
                         input bit rd, input bit wr);
        int t = 0;
        d_pmem_address = addr;
        d_pmem_wdata   = wd;
        d_pmem_read    = rd;
        d_pmem_write   = wr;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!d_pmem_resp && t < 200);
        if (!d_pmem_resp) begin
            n_cmp++;
            n_err++;
            $display("FAIL d_timeout: got no resp expected resp for addr %h", addr);
        end
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
    endtask

    task automatic push_g(input logic [AW-1:0] a, input bit wr, input logic [LW-1:0] wd);
        grant_t g;
        g.addr  = a;
        g.wr    = wr;
        g.wdata = wd;
        exp_grant.push_back(g);
    endtask

    task automatic push_r(input bit is_d, input logic [LW-1:0] data, input int cyc);
        resp_t r;
        r.is_d   = is_d;
        r.data   = data;
        r.cycles = cyc;
        exp_resp.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_read"}, mem_read, '0);
        chk({tag, "_mem_write"}, mem_write, '0);
        chk({tag, "_mem_address"}, mem_address, '0);
        chk({tag, "_mem_wdata"}, mem_wdata, '0);
        chk({tag, "_i_resp"}, i_pmem_resp, '0);
        chk({tag, "_d_resp"}, d_pmem_resp, '0);
    endtask

    initial begin
        logic [LW-1:0] wd;
        int t;
        rst_n = 1'b0;
        i_pmem_read = 1'b0;
        i_pmem_address = '0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata = '0;
        mem_model[32'h40] = {32{8'hA5}};
        #12;
        chk_all_zero("reset");
        chk("reset_i_rdata", i_pmem_rdata, '0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // single icache read, 4-cycle adaptor
        lat = 4;
        push_g(32'h40, 1'b0, '0);
        push_r(1'b0, {32{8'hA5}}, 4);
        run_i(32'h40);

        // dcache writeback then read-back of the same line
        wd = {16{16'h1234}};
        push_g(32'h1000, 1'b1, wd);
        push_r(1'b1, '0, 4);
        run_d(32'h1000, wd, 1'b0, 1'b1);
        push_g(32'h1000, 1'b0, '0);
        push_r(1'b1, {16{16'h1234}}, 4);
        run_d(32'h1000, '0, 1'b1, 1'b0);

        // simultaneous requests after reset: icache first
        do_reset();
        lat = 2;
        push_g(32'h100, 1'b0, '0);
        push_r(1'b0, {8{32'h100}}, 2);
        push_g(32'h200, 1'b0, '0);
        push_r(1'b1, {8{32'h200}}, 2);
        fork
            run_i(32'h100);
            run_d(32'h200, '0, 1'b1, 1'b0);
        join

        // continuous contention alternates I,D,I,D
        lat = 3;
        push_g(32'h400, 1'b0, '0);
        push_r(1'b0, {8{32'h400}}, 3);
        push_g(32'h800, 1'b0, '0);
        push_r(1'b1, {8{32'h800}}, 3);
        push_g(32'h440, 1'b0, '0);
        push_r(1'b0, {8{32'h440}}, 3);
        push_g(32'h840, 1'b0, '0);
        push_r(1'b1, {8{32'h840}}, 3);
        fork
            begin
                run_i(32'h400);
                run_i(32'h440);
            end
            begin
                run_d(32'h800, '0, 1'b1, 1'b0);
                run_d(32'h840, '0, 1'b1, 1'b0);
            end
        join

        // reset mid SERVE_D abandons the transaction
        lat = 20;
        push_g(32'h3000, 1'b0, '0);
        d_pmem_address = 32'h3000;
        d_pmem_wdata   = {8{32'hCAFEF00D}};
        d_pmem_read    = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!mem_read && t < 20);
        chk("serve_d_started", mem_read, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        d_pmem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stray = 1'b1;
        #1;
        chk("stray_i_resp", i_pmem_resp, '0);
        chk("stray_d_resp", d_pmem_resp, '0);
        @(negedge clk);
        stray = 1'b0;
        #1;

        // read+write together is a writeback
        lat = 3;
        wd = {8{32'hDEADBEEF}};
        push_g(32'h2000, 1'b1, wd);
        push_r(1'b1, '0, 3);
        run_d(32'h2000, wd, 1'b1, 1'b1);

        repeat (5) @(negedge clk);
        #2;
        chk("grant_queue_drained", exp_grant.size(), 0);
        chk("resp_queue_drained", exp_resp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
